mem_data_arbiter: RTL and testbench
===================================

MEM_DATA_ARBITER -- requirements
Module: mem_data_arbiter

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, data and address width.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 For each requester k in {0,1} the block SHALL have these ports: mk_req input 1, mk_we input 1 (1=write), mk_addr input XLEN, mk_wdata input XLEN, mk_len input 2 (0=byte, 1=half, 2=word), mk_sext input 1 (sign-extend read), mk_ack output 1 (request accepted), mk_done output 1 (operation complete), mk_rdata output XLEN.
REQ-005 Memory-side ports SHALL be: data_r_en output 1, data_addr_r output XLEN, data_r input XLEN, data_w_en output 1, data_addr_w output XLEN, data_w output XLEN, data_len_w output 2.
REQ-006 The block SHALL have port busy, output 1, high whenever the FSM is not IDLE.

Function
REQ-007 The FSM SHALL have states IDLE, WR, RD_ISSUE, RD_WAIT.
REQ-008 In IDLE with no mk_req high, the FSM SHALL remain in IDLE and drive all strobes low.
REQ-009 In IDLE with any mk_req high, the block SHALL select one winner, pulse that port's mk_ack for that cycle, and latch its we, addr, wdata, len, sext and index.
REQ-010 Arbitration SHALL be round-robin: with one requester it wins; with both, the port not granted most recently wins; after reset port 0 has priority.
REQ-011 From IDLE, a latched write SHALL go to WR and a latched read to RD_ISSUE.
REQ-012 WR SHALL last one cycle: data_w_en=1, data_addr_w/data_w/data_len_w from the latch, winner's mk_done=1; next state IDLE.
REQ-013 RD_ISSUE SHALL last one cycle: data_r_en=1, data_addr_r from the latch; next state RD_WAIT.
REQ-014 RD_WAIT SHALL last one cycle: winner's mk_done=1 and mk_rdata formatted from data_r; next state IDLE.
REQ-015 Read formatting SHALL be: len 0 -> data_r[7:0], len 1 -> data_r[15:0], len 2 or 3 -> data_r[31:0]; for len 0/1, upper bits fill with the sub-word MSB if sext=1, else zero.
REQ-016 Latency SHALL be: write accepted in cycle N completes (done) in N+1; read accepted in N has data_r_en in N+1 and done plus rdata in N+2.
REQ-017 mk_done SHALL be a single-cycle pulse and only on the granted port; the other port's ack/done SHALL stay low.
REQ-018 mk_rdata SHALL hold its last value except in RD_WAIT for that port, and SHALL be valid only while mk_done=1.
REQ-019 A write with len 3 SHALL still assert data_w_en for one cycle with data_len_w=3 and complete normally.
REQ-020 Requesters hold request fields stable from req to done; a req still high in the cycle after done SHALL be treated as a new request.
REQ-021 Requests arriving while busy SHALL wait, not be dropped, and SHALL be arbitrated at the next IDLE cycle.
REQ-022 Memory-side address/data outputs SHALL be driven from the latch at all times; only data_r_en and data_w_en qualify them.

Reset
REQ-023 On rst_n low the FSM SHALL enter IDLE immediately; latch, round-robin pointer (to port 0 priority), all mk_ack, mk_done, mk_rdata, busy, data_r_en, data_w_en and all memory-side address/data/len outputs SHALL be 0.
REQ-024 Reset mid-operation SHALL abort the operation with no done pulse; after release the aborted requester is served only if it still asserts req.

Verification
REQ-025 Write/read word: m0 write addr 0x100 data 0xDEADBEEF len 2 -> data_w_en one cycle at N+1; then m0 read 0x100 len 2 -> data_r_en at N+1, m0_done with m0_rdata=0xDEADBEEF at N+2.
REQ-026 Sub-word sign: memory word 0x000080F0 at 0x200; read len 0 sext 1 -> 0xFFFFFFF0; len 1 sext 0 -> 0x000080F0; len 1 sext 1 -> 0xFFFF80F0.
REQ-027 Contention: m0 and m1 both request reads every cycle after reset -> grants m0, m1, m0, m1; each done 3 cycles apart; ack/done never on both ports.
REQ-028 Waiting: m1 read arrives during m0's RD_ISSUE -> m1_ack in the IDLE cycle after m0_done; m1 not dropped.
REQ-029 Reset mid-read: rst_n low during RD_ISSUE -> all outputs 0 asynchronously, no m0_done; after release with m0_req low, FSM stays IDLE.
REQ-030 Byte write: m1 write addr 0x303 data 0x12345678 len 0 -> data_len_w=0, data_w=0x12345678, data_addr_w=0x303, m1_done at N+1.

Source files
------------

// File: rtl/mem_data_arbiter.sv
// mem_data_arbiter: round-robin arbiter between two load/store requesters and a
// single data memory port, with read sub-word formatting.
`default_nettype none

module mem_data_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic [1:0]      m0_len,
  input  logic            m0_sext,
  output logic            m0_ack,
  output logic            m0_done,
  output logic [XLEN-1:0] m0_rdata,

  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  input  logic [1:0]      m1_len,
  input  logic            m1_sext,
  output logic            m1_ack,
  output logic            m1_done,
  output logic [XLEN-1:0] m1_rdata,

  output logic            data_r_en,
  output logic [XLEN-1:0] data_addr_r,
  input  logic [XLEN-1:0] data_r,
  output logic            data_w_en,
  output logic [XLEN-1:0] data_addr_w,
  output logic [XLEN-1:0] data_w,
  output logic [1:0]      data_len_w,

  output logic            busy
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WR       = 2'd1;
  localparam logic [1:0] S_RD_ISSUE = 2'd2;
  localparam logic [1:0] S_RD_WAIT  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            we_q, sext_q, idx_q, prio_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [1:0]      len_q;
  logic [XLEN-1:0] rdata0_q, rdata1_q;

  logic            any_req;
  logic            grant_idx;
  logic            grant;
  logic [XLEN-1:0] rd_fmt;

  function automatic logic [XLEN-1:0] format_read(input logic [XLEN-1:0] d,
                                                  input logic [1:0]      len,
                                                  input logic            sext);
    logic [XLEN-1:0] r;
    case (len)
      2'd0:    r = {{(XLEN-8){sext & d[7]}}, d[7:0]};
      2'd1:    r = {{(XLEN-16){sext & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // prio_q names the port that wins a tie; it flips to the loser after every grant.
  always_comb begin
    any_req   = m0_req | m1_req;
    grant_idx = (m0_req && m1_req) ? prio_q : m1_req;
    grant     = (state_q == S_IDLE) && any_req;
    rd_fmt    = format_read(data_r, len_q, sext_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (any_req) state_d = (grant_idx ? m1_we : m0_we) ? S_WR : S_RD_ISSUE;
      S_WR:       state_d = S_IDLE;
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT:  state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      sext_q   <= 1'b0;
      idx_q    <= 1'b0;
      prio_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      len_q    <= 2'd0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        idx_q   <= grant_idx;
        prio_q  <= ~grant_idx;
        we_q    <= grant_idx ? m1_we    : m0_we;
        addr_q  <= grant_idx ? m1_addr  : m0_addr;
        wdata_q <= grant_idx ? m1_wdata : m0_wdata;
        len_q   <= grant_idx ? m1_len   : m0_len;
        sext_q  <= grant_idx ? m1_sext  : m0_sext;
      end
      if (state_q == S_RD_WAIT) begin
        if (idx_q) rdata1_q <= rd_fmt;
        else       rdata0_q <= rd_fmt;
      end
    end
  end

  // Ack is combinational so it lands in the acceptance cycle; gate it so it stays low in reset.
  always_comb begin
    m0_ack      = rst_n & grant & ~grant_idx;
    m1_ack      = rst_n & grant &  grant_idx;
    m0_done     = ((state_q == S_WR) || (state_q == S_RD_WAIT)) && !idx_q;
    m1_done     = ((state_q == S_WR) || (state_q == S_RD_WAIT)) &&  idx_q;
    m0_rdata    = ((state_q == S_RD_WAIT) && !idx_q) ? rd_fmt : rdata0_q;
    m1_rdata    = ((state_q == S_RD_WAIT) &&  idx_q) ? rd_fmt : rdata1_q;
    data_r_en   = (state_q == S_RD_ISSUE);
    data_w_en   = (state_q == S_WR);
    data_addr_r = addr_q;
    data_addr_w = addr_q;
    data_w      = wdata_q;
    data_len_w  = len_q;
    busy        = (state_q != S_IDLE);
  end

  logic unused_we;
  assign unused_we = we_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_data_arbiter.sv
// tb_mem_data_arbiter: directed vector table plus hand-written contention,
// waiting-requester and mid-read reset sequences for mem_data_arbiter.
`default_nettype none
`timescale 1ns/1ps

module tb_mem_data_arbiter;

  logic        clk, rst_n;
  logic        m0_req, m0_we, m0_sext, m0_ack, m0_done;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [1:0]  m0_len;
  logic        m1_req, m1_we, m1_sext, m1_ack, m1_done;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [1:0]  m1_len;
  logic        data_r_en, data_w_en, busy;
  logic [31:0] data_addr_r, data_r, data_addr_w, data_w;
  logic [1:0]  data_len_w;

  int errors = 0;
  int checks = 0;

  mem_data_arbiter #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_len(m0_len), .m0_sext(m0_sext), .m0_ack(m0_ack), .m0_done(m0_done),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_len(m1_len), .m1_sext(m1_sext), .m1_ack(m1_ack), .m1_done(m1_done),
    .m1_rdata(m1_rdata),
    .data_r_en(data_r_en), .data_addr_r(data_addr_r), .data_r(data_r),
    .data_w_en(data_w_en), .data_addr_w(data_addr_w), .data_w(data_w),
    .data_len_w(data_len_w), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-wide memory model with one cycle of read latency.
  logic [31:0] mem [logic [31:0]];
  always @(posedge clk) begin
    if (data_w_en) mem[data_addr_w] = data_w;
    if (data_r_en) data_r <= mem.exists(data_addr_r) ? mem[data_addr_r] : 32'h0;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input logic port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] len, input logic sext);
    if (!port) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_len = len; m0_sext = sext;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_len = len; m1_sext = sext;
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  len;
    logic        sext;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  // Entered at posedge+1 of an IDLE cycle; leaves at posedge+1 of the next IDLE cycle.
  task automatic do_txn(input vec_t v, input int n);
    logic ack_me, ack_ot, done_me, done_ot;
    logic [31:0] rd_me;
    set_req(v.port, 1'b1, v.we, v.addr, v.wdata, v.len, v.sext);
    @(negedge clk);
    ack_me = v.port ? m1_ack : m0_ack;
    ack_ot = v.port ? m0_ack : m1_ack;
    chk($sformatf("v%0d ack", n), {31'b0, ack_me}, 32'd1);
    chk($sformatf("v%0d other ack", n), {31'b0, ack_ot}, 32'd0);
    chk($sformatf("v%0d done idle", n), {30'b0, m0_done, m1_done}, 32'd0);
    chk($sformatf("v%0d busy idle", n), {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    set_req(v.port, 1'b0, v.we, v.addr, v.wdata, v.len, v.sext);
    @(negedge clk);
    done_me = v.port ? m1_done : m0_done;
    done_ot = v.port ? m0_done : m1_done;
    if (v.we) begin
      chk($sformatf("v%0d w_en", n), {31'b0, data_w_en}, 32'd1);
      chk($sformatf("v%0d addr_w", n), data_addr_w, v.addr);
      chk($sformatf("v%0d data_w", n), data_w, v.wdata);
      chk($sformatf("v%0d len_w", n), {30'b0, data_len_w}, {30'b0, v.len});
      chk($sformatf("v%0d wr done", n), {30'b0, done_me, done_ot}, 32'd2);
    end else begin
      chk($sformatf("v%0d r_en", n), {30'b0, data_r_en, data_w_en}, 32'd2);
      chk($sformatf("v%0d addr_r", n), data_addr_r, v.addr);
      chk($sformatf("v%0d issue done", n), {30'b0, m0_done, m1_done}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      done_me = v.port ? m1_done : m0_done;
      done_ot = v.port ? m0_done : m1_done;
      rd_me   = v.port ? m1_rdata : m0_rdata;
      chk($sformatf("v%0d rd done", n), {30'b0, done_me, done_ot}, 32'd2);
      chk($sformatf("v%0d rdata", n), rd_me, v.exp_rdata);
      chk($sformatf("v%0d r_en wait", n), {31'b0, data_r_en}, 32'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h100, 32'h0,        2'd2, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'h200, 32'h000080F0, 2'd2, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h200, 32'h0,        2'd0, 1'b1, 32'hFFFFFFF0};
    vecs[4] = '{1'b1, 1'b0, 32'h200, 32'h0,        2'd1, 1'b0, 32'h000080F0};
    vecs[5] = '{1'b1, 1'b0, 32'h200, 32'h0,        2'd1, 1'b1, 32'hFFFF80F0};
    vecs[6] = '{1'b1, 1'b1, 32'h303, 32'h12345678, 2'd0, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 2'd3, 1'b0, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 32'h400, 32'h0,        2'd3, 1'b0, 32'hCAFEF00D};
    vecs[9] = '{1'b0, 1'b0, 32'h200, 32'h0,        2'd0, 1'b0, 32'h000000F0};

    set_req(1'b0, 1'b1, 1'b1, 32'h55, 32'h66, 2'd2, 1'b0);
    set_req(1'b1, 1'b1, 1'b0, 32'h77, 32'h88, 2'd1, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst ack", {30'b0, m0_ack, m1_ack}, 32'd0);
    chk("rst done", {30'b0, m0_done, m1_done}, 32'd0);
    chk("rst strobes", {29'b0, busy, data_r_en, data_w_en}, 32'd0);
    chk("rst addr_w", data_addr_w, 32'h0);
    chk("rst addr_r", data_addr_r, 32'h0);
    chk("rst data_w", data_w, 32'h0);
    chk("rst len_w", {30'b0, data_len_w}, 32'h0);
    chk("rst rdata0", m0_rdata, 32'h0);
    chk("rst rdata1", m1_rdata, 32'h0);
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    @(negedge clk);
    chk("idle no req", {28'b0, busy, data_r_en, data_w_en, m0_ack}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) do_txn(vecs[i], i);

    // Contention from reset: grants alternate m0, m1 with one read every 3 cycles.
    reset_dut();
    set_req(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
    set_req(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 2'd2, 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("cont c%0d ack", c), {30'b0, m0_ack, m1_ack},
          {30'b0, (c % 6) == 0, (c % 6) == 3});
      chk($sformatf("cont c%0d done", c), {30'b0, m0_done, m1_done},
          {30'b0, (c % 6) == 2, (c % 6) == 5});
      if ((c % 6) == 2) chk($sformatf("cont c%0d rdata0", c), m0_rdata, 32'hDEADBEEF);
      if ((c % 6) == 5) chk($sformatf("cont c%0d rdata1", c), m1_rdata, 32'h000080F0);
      @(posedge clk); #1;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(posedge clk); #1;

    // m1 arrives during m0's RD_ISSUE and must be served right after m0 completes.
    set_req(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
    @(negedge clk);
    chk("wait m0 ack", {30'b0, m0_ack, m1_ack}, 32'd2);
    @(posedge clk); #1;
    m0_req = 1'b0;
    set_req(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 2'd0, 1'b1);
    @(negedge clk);
    chk("wait issue", {29'b0, m1_ack, data_r_en, busy}, 32'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait m0 done", {29'b0, m0_done, m1_ack, m1_done}, 32'd4);
    chk("wait m0 rdata", m0_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait m1 ack", {29'b0, m0_ack, m1_ack, busy}, 32'd2);
    @(posedge clk); #1;
    m1_req = 1'b0;
    @(negedge clk);
    chk("wait m1 issue", {31'b0, data_r_en}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait m1 done", {30'b0, m0_done, m1_done}, 32'd1);
    chk("wait m1 rdata", m1_rdata, 32'hFFFFFFF0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait m1 rdata hold", m1_rdata, 32'hFFFFFFF0);
    chk("wait done pulse", {30'b0, m0_done, m1_done}, 32'd0);
    @(posedge clk); #1;

    // Reset asserted during RD_ISSUE aborts the read with no done pulse.
    set_req(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
    @(negedge clk);
    chk("rstmid ack", {31'b0, m0_ack}, 32'd1);
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(negedge clk);
    chk("rstmid issue", {31'b0, data_r_en}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid async", {28'b0, data_r_en, busy, m0_done, m1_done}, 32'd0);
    chk("rstmid addr_r", data_addr_r, 32'h0);
    chk("rstmid rdata0", m0_rdata, 32'h0);
    @(negedge clk);
    chk("rstmid held", {29'b0, m0_done, busy, data_r_en}, 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid post c%0d", c), {28'b0, busy, m0_done, m0_ack, data_r_en}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
